// File: rtl/aes_dec_arbiter.sv
// aes_dec_arbiter: round-robin front end that shares one AES decode core
// between two requesters, with one response buffer per requester, a BUSY
// watchdog and a sticky error flag.
module aes_dec_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_v_i,
  input  logic         req1_v_i,
  output logic         req0_ready_o,
  output logic         req1_ready_o,
  input  logic [127:0] req0_data_i,
  input  logic [127:0] req1_data_i,
  input  logic [127:0] req0_key_i,
  input  logic [127:0] req1_key_i,
  output logic         rsp0_v_o,
  output logic         rsp1_v_o,
  input  logic         rsp0_ready_i,
  input  logic         rsp1_ready_i,
  output logic [127:0] rsp0_data_o,
  output logic [127:0] rsp1_data_o,
  output logic         core_data_v_o,
  output logic [127:0] core_data_o,
  output logic [127:0] core_key_o,
  input  logic         core_res_v_i,
  input  logic [127:0] core_res_i,
  output logic         busy_o,
  output logic         err_o
);
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // The counter holds k-1 in the k-th BUSY cycle, so the abort decision is
  // taken in BUSY cycle TIMEOUT, i.e. TIMEOUT cycles after the issue cycle.
  localparam logic [3:0] LAST_CNT = 4'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic              owner;
  logic              last;
  logic [3:0]        cnt;
  logic [1:0]        rsp_v;
  logic [1:0][127:0] rsp_data;
  logic              err;
  logic [1:0]        rsp_ready;
  logic              elig0, elig1, gnt0, gnt1;
  logic              res_take, timeout_hit, spurious;

  assign rsp_ready = {rsp1_ready_i, rsp0_ready_i};

  // Eligibility uses the registered response-valid, so a pop frees the
  // requester only from the following cycle on.
  assign elig0 = (state == IDLE) && !reset && req0_v_i && !rsp_v[0];
  assign elig1 = (state == IDLE) && !reset && req1_v_i && !rsp_v[1];
  // last == 1 means requester 1 went last, so requester 0 wins a tie.
  assign gnt0  = elig0 && (!elig1 || last);
  assign gnt1  = elig1 && (!elig0 || !last);

  assign res_take    = (state == BUSY) && core_res_v_i;
  assign timeout_hit = (state == BUSY) && !core_res_v_i && (cnt == LAST_CNT);
  assign spurious    = (state == IDLE) && core_res_v_i;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: issue on grant, return to IDLE on result or watchdog expiry.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt0 || gnt1) state_nxt = BUSY;
      BUSY:    if (res_take || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant handshake and core operands; operands are zero when nothing issues.
  always_comb begin
    req0_ready_o  = gnt0;
    req1_ready_o  = gnt1;
    core_data_v_o = gnt0 || gnt1;
    core_data_o   = '0;
    core_key_o    = '0;
    if (gnt1) begin
      core_data_o = req1_data_i;
      core_key_o  = req1_key_i;
    end else if (gnt0) begin
      core_data_o = req0_data_i;
      core_key_o  = req0_key_i;
    end
  end

  // Owner, pointer, watchdog counter, response buffers and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner    <= 1'b0;
      last     <= 1'b1;
      cnt      <= '0;
      rsp_v    <= '0;
      rsp_data <= '0;
      err      <= 1'b0;
    end else begin
      if (gnt0 || gnt1) begin
        owner <= gnt1;
        last  <= gnt1;
        cnt   <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt + 4'd1;
      end
      for (int i = 0; i < 2; i++)
        if (rsp_v[i] && rsp_ready[i]) rsp_v[i] <= 1'b0;
      // The owner's buffer is known empty here, so capture never races a pop.
      if (res_take) begin
        rsp_v[owner]    <= 1'b1;
        rsp_data[owner] <= core_res_i;
      end
      if (timeout_hit || spurious) err <= 1'b1;
    end
  end

  assign rsp0_v_o    = rsp_v[0];
  assign rsp1_v_o    = rsp_v[1];
  assign rsp0_data_o = rsp_data[0];
  assign rsp1_data_o = rsp_data[1];
  assign busy_o      = (state == BUSY);
  assign err_o       = err;

endmodule
